// File: rtl/counter_monitor.sv
// Passive checker for the 8-bit up/down counter: models the expected count and reports mismatches.
// Optional macro COUNTER_MONITOR_CAPTURE_EN adds capture of the first error's expected and observed values.
module counter_monitor #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mon_en,
    input  logic                 clr_err,
    input  logic                 cnt_rst,
    input  logic                 cnt_enable,
    input  logic                 cnt_direction,
    input  logic [WIDTH-1:0]     cnt_value,
    output logic                 err,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count,
`ifdef COUNTER_MONITOR_CAPTURE_EN
    output logic [WIDTH-1:0]     cap_expected,
    output logic [WIDTH-1:0]     cap_observed,
`endif
    output logic [1:0]           mon_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        CHECK = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      prev_value_q;
    logic                  prev_rst_q, prev_en_q, prev_dir_q;
    logic                  err_q, err_d;
    logic                  pulse_q, pulse_d;
    logic [1:0]            code_q, code_d;
    logic [ERR_CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]      expected;
    logic [1:0]            cause;
    logic                  mismatch;

    // Reference model driven purely by the previous edge's samples.
    always_comb begin
        expected = prev_value_q;
        cause    = 2'b01;
        if (prev_rst_q) begin
            expected = '0;
            cause    = 2'b00;
        end else if (!prev_en_q) begin
            expected = prev_value_q;
            cause    = 2'b01;
        end else if (prev_dir_q) begin
            expected = prev_value_q + WIDTH'(1);
            cause    = 2'b10;
        end else begin
            expected = prev_value_q - WIDTH'(1);
            cause    = 2'b11;
        end
    end

    assign mismatch = (state_q == CHECK) && mon_en && (cnt_value != expected);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mon_en) state_d = SYNC;
            SYNC:    state_d = mon_en ? CHECK : IDLE;
            CHECK:   if (!mon_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear is applied before the new error so a coincident mismatch survives.
    always_comb begin
        err_d   = err_q;
        code_d  = code_q;
        count_d = count_q;
        pulse_d = mismatch;
        if (clr_err) begin
            err_d   = 1'b0;
            code_d  = 2'b00;
            count_d = '0;
        end
        if (mismatch) begin
            err_d  = 1'b1;
            code_d = cause;
            if (count_d != '1) count_d = count_d + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prev_value_q <= '0;
            prev_rst_q   <= 1'b0;
            prev_en_q    <= 1'b0;
            prev_dir_q   <= 1'b0;
            err_q        <= 1'b0;
            pulse_q      <= 1'b0;
            code_q       <= 2'b00;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            prev_value_q <= cnt_value;
            prev_rst_q   <= cnt_rst;
            prev_en_q    <= cnt_enable;
            prev_dir_q   <= cnt_direction;
            err_q        <= err_d;
            pulse_q      <= pulse_d;
            code_q       <= code_d;
            count_q      <= count_d;
        end
    end

`ifdef COUNTER_MONITOR_CAPTURE_EN
    logic             cap_valid_q, cap_valid_d;
    logic [WIDTH-1:0] cap_exp_q, cap_exp_d;
    logic [WIDTH-1:0] cap_obs_q, cap_obs_d;

    always_comb begin
        cap_valid_d = cap_valid_q;
        cap_exp_d   = cap_exp_q;
        cap_obs_d   = cap_obs_q;
        if (clr_err) cap_valid_d = 1'b0;
        if (mismatch && !cap_valid_d) begin
            cap_valid_d = 1'b1;
            cap_exp_d   = expected;
            cap_obs_d   = cnt_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_q <= 1'b0;
            cap_exp_q   <= '0;
            cap_obs_q   <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_exp_q   <= cap_exp_d;
            cap_obs_q   <= cap_obs_d;
        end
    end

    assign cap_expected = cap_exp_q;
    assign cap_observed = cap_obs_q;
`endif

    assign err       = err_q;
    assign err_pulse = pulse_q;
    assign err_code  = code_q;
    assign err_count = count_q;
    assign mon_state = state_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed self-checking bench for counter_monitor; capture checks enabled with COUNTER_MONITOR_CAPTURE_EN.
module tb_counter_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mon_en;
    logic       clr_err;
    logic       cnt_rst;
    logic       cnt_enable;
    logic       cnt_direction;
    logic [7:0] cnt_value;
    logic       err;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] err_count;
    logic [1:0] mon_state;
`ifdef COUNTER_MONITOR_CAPTURE_EN
    logic [7:0] cap_expected;
    logic [7:0] cap_observed;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    counter_monitor #(.WIDTH(8), .ERR_CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mon_en       (mon_en),
        .clr_err      (clr_err),
        .cnt_rst      (cnt_rst),
        .cnt_enable   (cnt_enable),
        .cnt_direction(cnt_direction),
        .cnt_value    (cnt_value),
        .err          (err),
        .err_pulse    (err_pulse),
        .err_code     (err_code),
        .err_count    (err_count),
`ifdef COUNTER_MONITOR_CAPTURE_EN
        .cap_expected (cap_expected),
        .cap_observed (cap_observed),
`endif
        .mon_state    (mon_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one set of counter signals, clock it in, and settle past the edge.
    task automatic drive(input logic r, input logic en, input logic dir, input logic [7:0] v);
        cnt_rst       = r;
        cnt_enable    = en;
        cnt_direction = dir;
        cnt_value     = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mon_en = 1'b1; clr_err = 1'b0;
        cnt_rst = 1'b0; cnt_enable = 1'b0; cnt_direction = 1'b0; cnt_value = '0;

        for (int i = 0; i < 2; i++)
            drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        check("rst_state", 32'(mon_state), 0);
        check("rst_err",   32'(err), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_code",  32'(err_code), 0);
        check("rst_count", 32'(err_count), 0);

        rst_n = 1'b1;
        drive(0, 1, 1, 8'd250);
        check("state_sync", 32'(mon_state), 1);
        drive(0, 1, 1, 8'd251);
        check("state_check", 32'(mon_state), 2);

        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 8'(252 + i));
            check("up_pulse", 32'(err_pulse), 0);
        end
        check("up_err",   32'(err), 0);
        check("up_count", 32'(err_count), 0);

        // Last value was 5 counting up; steer to 2 then count down.
        drive(1, 1, 1, 8'd6);
        drive(0, 1, 1, 8'd0);
        drive(0, 1, 1, 8'd1);
        drive(0, 1, 0, 8'd2);
        drive(0, 1, 0, 8'd1);
        drive(0, 1, 0, 8'd0);
        drive(0, 1, 0, 8'd255);
        drive(0, 0, 0, 8'd254);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'd254);
        check("down_err",   32'(err), 0);
        check("down_count", 32'(err_count), 0);

        drive(1, 0, 0, 8'd254);
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 8'(i));
        drive(0, 0, 0, 8'd10);
        check("pre_fault_pulse", 32'(err_pulse), 0);
        drive(0, 0, 0, 8'd11);
        check("hold_pulse", 32'(err_pulse), 1);
        check("hold_code",  32'(err_code), 1);
        check("hold_err",   32'(err), 1);
        check("hold_count", 32'(err_count), 1);
        drive(1, 0, 0, 8'd11);
        check("pulse_one_cycle", 32'(err_pulse), 0);
        check("err_sticky",      32'(err), 1);
        drive(0, 0, 0, 8'd5);
        check("rst_fault_pulse", 32'(err_pulse), 1);
        check("rst_fault_code",  32'(err_code), 0);
        check("rst_fault_count", 32'(err_count), 2);

        for (int i = 0; i < 300; i++) drive(0, 0, 0, 8'(6 + i));
        check("sat_count", 32'(err_count), 255);
        check("sat_pulse", 32'(err_pulse), 1);

        clr_err = 1'b1;
        drive(0, 0, 0, 8'd50);
        check("clr_mis_count", 32'(err_count), 1);
        check("clr_mis_err",   32'(err), 1);
        check("clr_mis_code",  32'(err_code), 1);
        drive(0, 0, 0, 8'd50);
        clr_err = 1'b0;
        check("clr_count", 32'(err_count), 0);
        check("clr_err",   32'(err), 0);

        mon_en = 1'b0;
        drive(0, 0, 0, 8'd7);
        check("gap_pulse0", 32'(err_pulse), 0);
        drive(0, 0, 0, 8'd7);
        drive(0, 0, 0, 8'd99);
        drive(0, 0, 0, 8'd99);
        check("gap_pulse3", 32'(err_pulse), 0);
        check("gap_state",  32'(mon_state), 0);
        check("gap_count",  32'(err_count), 0);
        mon_en = 1'b1;
        drive(0, 0, 0, 8'd99);
        check("reen_sync", 32'(mon_state), 1);
        drive(0, 0, 0, 8'd42);
        check("reen_check", 32'(mon_state), 2);
        check("reen_pulse_sync", 32'(err_pulse), 0);
        drive(0, 0, 0, 8'd42);
        check("reen_pulse", 32'(err_pulse), 0);
        check("reen_err",   32'(err), 0);

        drive(1, 0, 0, 8'd42);
        for (int i = 0; i <= 20; i++) drive(0, 1, 1, 8'(i));
        drive(0, 1, 1, 8'd23);
        check("up_fault_pulse", 32'(err_pulse), 1);
        check("up_fault_code",  32'(err_code), 2);
        check("up_fault_count", 32'(err_count), 1);
`ifdef COUNTER_MONITOR_CAPTURE_EN
        check("cap_exp", 32'(cap_expected), 21);
        check("cap_obs", 32'(cap_observed), 23);
`endif
        drive(0, 1, 1, 8'd30);
        check("second_fault_count", 32'(err_count), 2);
`ifdef COUNTER_MONITOR_CAPTURE_EN
        check("cap_exp_frozen", 32'(cap_expected), 21);
        check("cap_obs_frozen", 32'(cap_observed), 23);
`endif

        // Asynchronous reset mid-CHECK clears everything without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("async_state", 32'(mon_state), 0);
        check("async_err",   32'(err), 0);
        check("async_count", 32'(err_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
